// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit for the E stage: owns HI/LO, runs
// mult/multu/div/divu with a fixed busy period, and does mthi/mtlo in one edge.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CW = $clog2(((MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES) + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_temp_hi, r_temp_lo;
  logic [31:0]   r_hi, r_lo;

  logic        w_signed;
  logic [63:0] w_a_ext, w_b_ext, w_prod;
  logic        w_a_neg, w_b_neg;
  logic [31:0] w_a_mag, w_b_mag, w_b_div;
  logic [31:0] w_q_mag, w_r_mag, w_q, w_r;
  logic [31:0] w_res_hi, w_res_lo;

  // One shared multiplier: the low 64 bits of the extended product give the
  // signed or unsigned result depending on how the operands are extended.
  assign w_signed = (MDUOp == OP_MULT) || (MDUOp == OP_DIV);
  assign w_a_ext  = {{32{w_signed & A[31]}}, A};
  assign w_b_ext  = {{32{w_signed & B[31]}}, B};
  assign w_prod   = w_a_ext * w_b_ext;

  // Signed divide works on magnitudes; 0x80000000 / -1 falls out as 0x80000000.
  assign w_a_neg = w_signed & A[31];
  assign w_b_neg = w_signed & B[31];
  assign w_a_mag = w_a_neg ? (~A + 32'd1) : A;
  assign w_b_mag = w_b_neg ? (~B + 32'd1) : B;
  assign w_b_div = (B == 32'd0) ? 32'd1 : w_b_mag;
  assign w_q_mag = w_a_mag / w_b_div;
  assign w_r_mag = w_a_mag % w_b_div;
  assign w_q     = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_r     = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    w_res_hi = r_hi;
    w_res_lo = r_lo;
    case (MDUOp)
      OP_MULT, OP_MULTU: {w_res_hi, w_res_lo} = w_prod;
      OP_DIV, OP_DIVU: begin
        // Divide by zero keeps the current HI/LO so the commit is a no-op.
        if (B != 32'd0) begin
          w_res_hi = w_r;
          w_res_lo = w_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments only.
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_temp_hi <= '0;
      r_temp_lo <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (MDUOp)
              OP_MULT, OP_MULTU: begin
                r_temp_hi <= w_res_hi;
                r_temp_lo <= w_res_lo;
                r_cnt     <= MULT_LOAD;
                r_state   <= S_BUSY;
              end
              OP_DIV, OP_DIVU: begin
                r_temp_hi <= w_res_hi;
                r_temp_lo <= w_res_lo;
                r_cnt     <= DIV_LOAD;
                r_state   <= S_BUSY;
              end
              OP_MTHI: r_hi <= A;
              OP_MTLO: r_lo <= A;
              default: ;
            endcase
          end
        end
        default: begin
          // Any start arriving while busy is deliberately ignored.
          if (r_cnt == CW'(1)) begin
            r_hi    <= r_temp_hi;
            r_lo    <= r_temp_lo;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
      endcase
    end
  end

  assign busy = (r_state == S_BUSY);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed cases plus randomized operations
// compared against a plain-arithmetic model of the HI/LO registers.
module tb_mdu_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  logic        start1;
  logic [2:0]  op1;
  logic [31:0] a1, b1;
  logic        busy1;
  logic [31:0] hi1, lo1;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) u_dut (
    .clk(clk), .reset(reset), .start(start), .MDUOp(op), .A(a), .B(b),
    .busy(busy), .HI(hi), .LO(lo)
  );

  mdu_unit #(.MULT_CYCLES(1), .DIV_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .MDUOp(op1), .A(a1), .B(b1),
    .busy(busy1), .HI(hi1), .LO(lo1)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Architectural effect of one accepted operation on HI/LO.
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd1: begin p = 64'(sx * sy); m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2: begin p = {32'd0, x} * {32'd0, y}; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd3: if (y != 0) begin m_lo = 32'(sx / sy); m_hi = 32'(sx % sy); end
      3'd4: if (y != 0) begin m_lo = x / y; m_hi = x % y; end
      3'd5: m_hi = x;
      3'd6: m_lo = x;
      default: ;
    endcase
  endtask

  function automatic int busy_len(input logic st, input logic [2:0] o);
    if (!st) return 0;
    if (o == 3'd1 || o == 3'd2) return MC;
    if (o == 3'd3 || o == 3'd4) return DC;
    return 0;
  endfunction

  // Called at a falling edge; returns at the falling edge where busy is low again.
  task automatic run_op(input string tag, input logic st, input logic [2:0] o,
                        input logic [31:0] x, input logic [31:0] y);
    int cyc, exp_cyc;
    logic [31:0] old_hi, old_lo;
    old_hi  = m_hi;
    old_lo  = m_lo;
    exp_cyc = busy_len(st, o);
    if (st) model(o, x, y);
    start = st; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    op = 3'($urandom_range(0, 7));
    a = $urandom;
    b = $urandom;
    cyc = 0;
    while (busy && cyc < DC + 5) begin
      check({tag, " hold"}, {hi, lo}, {old_hi, old_lo});
      cyc++;
      @(negedge clk);
    end
    check({tag, " busy cycles"}, 64'(cyc), 64'(exp_cyc));
    check({tag, " HI"}, 64'(hi), 64'(m_hi));
    check({tag, " LO"}, 64'(lo), 64'(m_lo));
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic        st;
    logic [2:0]  o;
    logic [31:0] x, y;

    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    start1 = 1'b0; op1 = '0; a1 = '0; b1 = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy), 64'(0));
    check("reset HI", 64'(hi), 64'(0));
    check("reset LO", 64'(lo), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // Reset mid-operation: non-zero HI/LO first, then abort a DIV in cycle 3.
    run_op("mthi pre", 1'b1, 3'd5, 32'hAAAA, 32'h0);
    run_op("mtlo pre", 1'b1, 3'd6, 32'hBBBB, 32'h0);
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("midrst busy", 64'(busy), 64'(0));
    check("midrst HI", 64'(hi), 64'(0));
    check("midrst LO", 64'(lo), 64'(0));
    @(negedge clk); reset = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (DC + 3) @(negedge clk);
    check("midrst no commit", {hi, lo}, 64'(0));
    check("midrst idle", 64'(busy), 64'(0));

    // Start while busy: MTLO issued in busy cycle 2 must be dropped.
    model(3'd1, 32'd3, 32'd4);
    start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < DC + 5) begin
      if (cyc == 1) begin start = 1'b1; op = 3'd6; a = 32'hDEAD; end
      else start = 1'b0;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    check("sib busy cycles", 64'(cyc), 64'(MC));
    check("sib LO", 64'(lo), 64'(32'd12));
    check("sib HI", 64'(hi), 64'(32'd0));

    run_op("mult -2*3", 1'b1, 3'd1, 32'hFFFFFFFE, 32'd3);
    check("mult HI const", 64'(hi), 64'(32'hFFFFFFFF));
    run_op("multu", 1'b1, 3'd2, 32'hFFFFFFFE, 32'd3);
    check("multu HI const", 64'(hi), 64'(32'h00000002));
    run_op("div -7/2", 1'b1, 3'd3, 32'hFFFFFFF9, 32'd2);
    check("div LO const", 64'(lo), 64'(32'hFFFFFFFD));
    run_op("divu 7/2", 1'b1, 3'd4, 32'd7, 32'd2);

    run_op("mthi", 1'b1, 3'd5, 32'h1234, 32'h0);
    run_op("mtlo", 1'b1, 3'd6, 32'h5678, 32'h0);
    run_op("div by zero", 1'b1, 3'd3, 32'd99, 32'd0);
    check("div0 HI LO const", {hi, lo}, {32'h1234, 32'h5678});
    run_op("divu by zero", 1'b1, 3'd4, 32'd99, 32'd0);

    run_op("div overflow", 1'b1, 3'd3, 32'h80000000, 32'hFFFFFFFF);
    check("ovf LO const", 64'(lo), 64'(32'h80000000));
    run_op("b2b multu", 1'b1, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("b2b const", {hi, lo}, {32'hFFFFFFFE, 32'h00000001});

    run_op("no start", 1'b0, 3'd1, 32'd5, 32'd6);
    run_op("op none", 1'b1, 3'd0, 32'd5, 32'd6);
    run_op("op reserved", 1'b1, 3'd7, 32'd5, 32'd6);

    for (int i = 0; i < 40; i++) begin
      st = ($urandom_range(0, 3) != 0);
      o  = 3'($urandom_range(0, 7));
      x  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0:       y = 32'd0;
        1:       y = 32'hFFFFFFFF;
        2, 3:    y = 32'($urandom_range(1, 20));
        default: y = $urandom;
      endcase
      run_op("random", st, o, x, y);
    end

    // Single-cycle configuration: busy for exactly one cycle.
    start1 = 1'b1; op1 = 3'd1; a1 = 32'hFFFFFFFE; b1 = 32'd3;
    @(negedge clk); start1 = 1'b0;
    check("n1 mult busy", 64'(busy1), 64'(1));
    @(negedge clk);
    check("n1 mult done", 64'(busy1), 64'(0));
    check("n1 mult HI LO", {hi1, lo1}, {32'hFFFFFFFF, 32'hFFFFFFFA});
    start1 = 1'b1; op1 = 3'd4; a1 = 32'd7; b1 = 32'd2;
    @(negedge clk); start1 = 1'b0;
    check("n1 divu busy", 64'(busy1), 64'(1));
    @(negedge clk);
    check("n1 divu done", 64'(busy1), 64'(0));
    check("n1 divu HI LO", {hi1, lo1}, {32'd1, 32'd3});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
